// File: rtl/mult_arb_pkg.sv
// Shared types and constants for the multiplier arbiter.
// Operand/product widths and the default requester count and latency.
package mult_arb_pkg;

    localparam int OP_W        = 8;
    localparam int PROD_W      = 16;
    localparam int N_REQ_DEF   = 4;
    localparam int MUL_LAT_DEF = 2;

    typedef logic [OP_W-1:0]   op_t;
    typedef logic [PROD_W-1:0] prod_t;

    // One carry-save (3:2) step on whole words: {carry, sum}.
    function automatic logic [2*PROD_W-1:0] csa(
        input prod_t a,
        input prod_t b,
        input prod_t c
    );
        prod_t s;
        prod_t cy;
        s  = a ^ b ^ c;
        cy = ((a & b) | (a & c) | (b & c)) << 1;
        return {cy, s};
    endfunction

endpackage

// File: rtl/wallace1.sv
// 8x8 unsigned Wallace-tree multiplier, purely combinational.
// Ports: clock (reference clock for the self-check), x, y operands, p product.
module wallace1
    import mult_arb_pkg::*;
(
    input  logic  clock,
    input  op_t   x,
    input  op_t   y,
    output prod_t p
);

    prod_t pp [OP_W];
    prod_t l1 [6];
    prod_t l2 [4];
    prod_t l3 [3];
    prod_t l4 [2];

    always_comb begin
        for (int i = 0; i < OP_W; i++) begin
            pp[i] = y[i] ? (prod_t'(x) << i) : '0;
        end
        // 8 rows -> 6 -> 4 -> 3 -> 2, then one carry-propagate add.
        {l1[1], l1[0]} = csa(pp[0], pp[1], pp[2]);
        {l1[3], l1[2]} = csa(pp[3], pp[4], pp[5]);
        l1[4]          = pp[6];
        l1[5]          = pp[7];
        {l2[1], l2[0]} = csa(l1[0], l1[1], l1[2]);
        {l2[3], l2[2]} = csa(l1[3], l1[4], l1[5]);
        {l3[1], l3[0]} = csa(l2[0], l2[1], l2[2]);
        l3[2]          = l2[3];
        {l4[1], l4[0]} = csa(l3[0], l3[1], l3[2]);
        p              = l4[0] + l4[1];
    end

    // Simulation-only guard that the reduction tree is exact.
    a_exact: assert property (@(posedge clock) p == prod_t'(x) * prod_t'(y));

endmodule

// File: rtl/mult_arbiter.sv
// Round-robin arbiter sharing one pipelined 8x8 multiplier among N_REQ requesters.
// Ports: clock, reset (sync, high), enable, req/req_x/req_y in; gnt, rsp_valid, rsp_id, product, busy, ops_done out.
module mult_arbiter
    import mult_arb_pkg::*;
#(
    parameter int N_REQ   = N_REQ_DEF,
    parameter int MUL_LAT = MUL_LAT_DEF
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     enable,
    input  logic [N_REQ-1:0]         req,
    input  logic [OP_W*N_REQ-1:0]    req_x,
    input  logic [OP_W*N_REQ-1:0]    req_y,
    output logic [N_REQ-1:0]         gnt,
    output logic                     rsp_valid,
    output logic [$clog2(N_REQ)-1:0] rsp_id,
    output prod_t                    product,
    output logic                     busy,
    output logic [15:0]              ops_done
);

    localparam int IDW = $clog2(N_REQ);
    localparam logic [IDW:0]   NREQ_W  = (IDW+1)'(N_REQ);
    localparam logic [IDW-1:0] LAST_ID = IDW'(N_REQ - 1);

    typedef logic [IDW-1:0] id_t;

    id_t          ptr;
    id_t          win;
    logic         hit;
    logic [IDW:0] cand;

    logic  op_v;
    op_t   op_x;
    op_t   op_y;
    id_t   op_id;
    prod_t mul_p;

    logic [MUL_LAT-1:0] st_v;
    prod_t              st_p  [MUL_LAT];
    id_t                st_id [MUL_LAT];

    // Search upward from ptr, wrapping at N_REQ; first asserted req wins.
    always_comb begin
        hit  = 1'b0;
        win  = '0;
        cand = '0;
        gnt  = '0;
        if (enable && !reset) begin
            for (int k = 0; k < N_REQ; k++) begin
                cand = {1'b0, ptr} + (IDW+1)'(k);
                if (cand >= NREQ_W) begin
                    cand = cand - NREQ_W;
                end
                if (!hit && req[cand[IDW-1:0]]) begin
                    hit = 1'b1;
                    win = cand[IDW-1:0];
                end
            end
        end
        if (hit) begin
            gnt[win] = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ptr <= '0;
        end else if (hit) begin
            ptr <= (win == LAST_ID) ? '0 : win + IDW'(1);
        end
    end

    // Operand register; data holds when no grant, only the valid drops.
    always_ff @(posedge clock) begin
        if (reset) begin
            op_v  <= 1'b0;
            op_x  <= '0;
            op_y  <= '0;
            op_id <= '0;
        end else begin
            op_v <= hit;
            if (hit) begin
                op_x  <= req_x[win*OP_W +: OP_W];
                op_y  <= req_y[win*OP_W +: OP_W];
                op_id <= win;
            end
        end
    end

    wallace1 u_mul (
        .clock (clock),
        .x     (op_x),
        .y     (op_y),
        .p     (mul_p)
    );

    // Result stages load data only behind a valid, so the last stage
    // (the response port) holds its value between results.
    always_ff @(posedge clock) begin
        if (reset) begin
            st_v <= '0;
            for (int s = 0; s < MUL_LAT; s++) begin
                st_p[s]  <= '0;
                st_id[s] <= '0;
            end
        end else begin
            st_v[0] <= op_v;
            if (op_v) begin
                st_p[0]  <= mul_p;
                st_id[0] <= op_id;
            end
            for (int s = 1; s < MUL_LAT; s++) begin
                st_v[s] <= st_v[s-1];
                if (st_v[s-1]) begin
                    st_p[s]  <= st_p[s-1];
                    st_id[s] <= st_id[s-1];
                end
            end
        end
    end

    assign rsp_valid = st_v[MUL_LAT-1];
    assign product   = st_p[MUL_LAT-1];
    assign rsp_id    = st_id[MUL_LAT-1];
    assign busy      = op_v | (|st_v);

    always_ff @(posedge clock) begin
        if (reset) begin
            ops_done <= '0;
        end else if (rsp_valid && ops_done != 16'hFFFF) begin
            ops_done <= ops_done + 16'd1;
        end
    end

endmodule

// File: tb/tb_mult_arbiter.sv
// Randomized and directed bench for mult_arbiter against a cycle-level model.
// Model tracks pointer, outstanding results with due cycles, and the done count.
module tb_mult_arbiter;

    localparam int N = 4;
    localparam int L = 2;

    logic           clock = 1'b0;
    logic           reset;
    logic           enable;
    logic [N-1:0]   req;
    logic [8*N-1:0] req_x;
    logic [8*N-1:0] req_y;
    logic [N-1:0]   gnt;
    logic           rsp_valid;
    logic [1:0]     rsp_id;
    logic [15:0]    product;
    logic           busy;
    logic [15:0]    ops_done;

    mult_arbiter #(.N_REQ(N), .MUL_LAT(L)) dut (
        .clock     (clock),
        .reset     (reset),
        .enable    (enable),
        .req       (req),
        .req_x     (req_x),
        .req_y     (req_y),
        .gnt       (gnt),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .product   (product),
        .busy      (busy),
        .ops_done  (ops_done)
    );

    always #5 clock = ~clock;

    typedef struct {
        int due;
        int id;
        int prod;
    } exp_t;

    exp_t pend [$];
    int   mptr      = 0;
    int   mcount    = 0;
    int   cyc       = 0;
    int   last_id   = 0;
    int   last_prod = 0;
    int   n_checks  = 0;
    int   n_fail    = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h",
                     tag, cyc, got, exp);
        end
    endtask

    // Compare this cycle's outputs, then advance the model past the edge.
    task automatic model_cycle();
        int   w;
        int   i;
        logic rv;
        exp_t e;
        w = -1;
        if (!reset && enable) begin
            for (int k = 0; k < N; k++) begin
                i = (mptr + k) % N;
                if (w < 0 && req[i]) w = i;
            end
        end
        check("gnt", 32'(gnt), (w >= 0) ? (32'd1 << w) : 32'd0);
        rv = (pend.size() > 0) && (pend[0].due == cyc);
        check("rsp_valid", 32'(rsp_valid), 32'(rv));
        if (rv) begin
            last_id   = pend[0].id;
            last_prod = pend[0].prod;
        end
        check("rsp_id", 32'(rsp_id), 32'(last_id));
        check("product", 32'(product), 32'(last_prod));
        check("busy", 32'(busy), 32'(pend.size() > 0));
        check("ops_done", 32'(ops_done), 32'(mcount));
        if (rv) begin
            void'(pend.pop_front());
            if (!reset && mcount < 65535) mcount++;
        end
        if (reset) begin
            pend.delete();
            mptr      = 0;
            mcount    = 0;
            last_id   = 0;
            last_prod = 0;
        end else if (w >= 0) begin
            e.due  = cyc + L + 1;
            e.id   = w;
            e.prod = int'(req_x[8*w +: 8]) * int'(req_y[8*w +: 8]);
            pend.push_back(e);
            mptr = (w + 1) % N;
        end
        cyc++;
    endtask

    task automatic tick();
        @(negedge clock);
        model_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic set_op(input int i, input logic [7:0] x,
                          input logic [7:0] y);
        req_x[8*i +: 8] = x;
        req_y[8*i +: 8] = y;
    endtask

    task automatic rand_ops();
        for (int i = 0; i < N; i++) begin
            case ($urandom_range(0, 5))
                0:       set_op(i, 8'hFF, 8'($urandom));
                1:       set_op(i, 8'h00, 8'($urandom));
                2:       set_op(i, 8'hFF, 8'hFF);
                default: set_op(i, 8'($urandom), 8'($urandom));
            endcase
        end
    endtask

    initial begin
        int extra;
        reset  = 1'b1;
        enable = 1'b0;
        req    = '0;
        req_x  = '0;
        req_y  = '0;
        @(posedge clock);
        #1;
        tick();
        reset = 1'b0;
        tick();

        // Single request, largest operands.
        enable = 1'b1;
        req    = 4'b0001;
        set_op(0, 8'hFF, 8'hFF);
        tick();
        req = '0;
        repeat (3) tick();
        check("ff_x_ff", 32'(product), 32'hFE01);
        repeat (2) tick();

        // Full contention for five cycles.
        rand_ops();
        req = 4'b1111;
        repeat (5) tick();
        req = '0;
        repeat (5) tick();

        // Back-to-back on requester 1.
        req = 4'b0010;
        set_op(1, 8'h0C, 8'h0D);
        tick();
        set_op(1, 8'h00, 8'hAB);
        tick();
        req = '0;
        repeat (5) tick();

        // Disable while two operations are in flight.
        rand_ops();
        req = 4'b0011;
        repeat (2) tick();
        enable = 1'b0;
        req    = 4'b1111;
        repeat (6) tick();
        check("busy_drained", 32'(busy), 32'd0);

        // Reset one cycle after a grant.
        enable = 1'b1;
        req    = 4'b0001;
        tick();
        req   = '0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        req   = 4'b1000;
        tick();
        req = '0;
        repeat (5) tick();

        // Random traffic with occasional disable and reset.
        for (int c = 0; c < 300; c++) begin
            rand_ops();
            req    = N'($urandom_range(0, 15));
            enable = ($urandom_range(0, 9) != 0);
            reset  = ($urandom_range(0, 49) == 0);
            tick();
        end
        reset  = 1'b0;
        enable = 1'b1;

        // Saturate the completion counter.
        req   = 4'b1111;
        extra = 0;
        for (int c = 0; c < 70000 && extra < 4; c++) begin
            if ((c & 255) == 0) rand_ops();
            tick();
            if (mcount == 65535) extra++;
        end
        req = '0;
        repeat (5) tick();
        check("ops_sat", 32'(ops_done), 32'hFFFF);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
